pcie_msi_scheduler: RTL and testbench

//  Shares the single MSI request port of the Arria 10 / Cyclone 10 PCIe hard IP between NUM_REQ

---
 rtl/pcie_msi_if.sv | 22 ++
 rtl/pcie_msi_scheduler.sv | 127 ++++++++++++
 tb/tb_pcie_msi_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_msi_if.sv
// MSI request/acknowledge handshake between the scheduler and the PCIe hard IP.
// The scheduler is the master; the hard IP (or a bench model of it) is the slave.
interface pcie_msi_if;
    logic       app_msi_req;
    logic [4:0] app_msi_num;
    logic [2:0] app_msi_tc;
    logic       app_msi_ack;

    modport master (
        output app_msi_req,
        output app_msi_num,
        output app_msi_tc,
        input  app_msi_ack
    );

    modport slave (
        input  app_msi_req,
        input  app_msi_num,
        input  app_msi_tc,
        output app_msi_ack
    );
endinterface

// File: rtl/pcie_msi_scheduler.sv
// Round-robin arbiter that funnels NUM_REQ interrupt events onto the single HIP MSI port.
// Events are latched as pending bits and retired on app_msi_ack; a missing ack aborts after ACK_TIMEOUT.
module pcie_msi_scheduler #(
    parameter int         NUM_REQ     = 8,
    parameter int         ACK_TIMEOUT = 1024,
    parameter int         GAP_CYCLES  = 4,
    parameter logic [2:0] MSI_TC      = 3'd0
) (
    input  logic               pld_clk,
    input  logic               rst,
    input  logic               msi_enable,
    input  logic [NUM_REQ-1:0] req_pulse,
    pcie_msi_if.master         msi,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t             state;
    logic [4:0]         ptr_q;
    logic [4:0]         sel_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               ack_in_req;
    logic [NUM_REQ-1:0] clr_mask;
    logic               hi_found;
    logic [4:0]         hi_sel;
    logic [4:0]         lo_sel;
    logic [4:0]         rr_sel;

    assign msi.app_msi_tc  = MSI_TC;
    assign msi.app_msi_num = sel_q;
    assign busy            = (state != IDLE);
    assign ack_in_req      = (state == REQ) && msi.app_msi_ack;

    // Lowest pending bit above the pointer wins; failing that, wrap to the lowest pending bit.
    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_sel = 5'(i);
                if (5'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_sel   = 5'(i);
                end
            end
        end
        rr_sel = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        clr_mask = '0;
        if (ack_in_req) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel_q == 5'(i)) begin
                    clr_mask[i] = 1'b1;
                end
            end
        end
    end

    // A new pulse on the bit being acknowledged survives because the set term is ORed in last.
    always_ff @(posedge pld_clk) begin
        if (rst) begin
            state           <= IDLE;
            msi.app_msi_req <= 1'b0;
            sel_q           <= '0;
            ptr_q           <= 5'(NUM_REQ - 1);
            pending         <= '0;
            tmo_cnt         <= '0;
            gap_cnt         <= '0;
            timeout_err     <= 1'b0;
        end else begin
            pending     <= (pending & ~clr_mask) | req_pulse;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (msi_enable && (pending != '0)) begin
                        sel_q           <= rr_sel;
                        msi.app_msi_req <= 1'b1;
                        tmo_cnt         <= '0;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (msi.app_msi_ack) begin
                        ptr_q           <= sel_q;
                        msi.app_msi_req <= 1'b0;
                        gap_cnt         <= '0;
                        state           <= GAP;
                    end else if (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        ptr_q           <= sel_q;
                        msi.app_msi_req <= 1'b0;
                        timeout_err     <= 1'b1;
                        gap_cnt         <= '0;
                        state           <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state           <= IDLE;
                    msi.app_msi_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_msi_scheduler.sv
// Directed bench for pcie_msi_scheduler: expected MSI grants are queued by the stimulus,
// and a monitor that also plays the HIP ack side pops and compares each request.
module tb_pcie_msi_scheduler;

    localparam int NUM_REQ     = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int GAP_CYCLES  = 4;

    // delay >= 0: ack after that many further req cycles; -1: never ack (timeout); -2: reset will cut it
    typedef struct {
        int num;
        int delay;
        bit repulse;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               msi_enable = 1'b0;
    logic [NUM_REQ-1:0] main_pulse = '0;
    logic [NUM_REQ-1:0] mon_pulse = '0;
    logic [NUM_REQ-1:0] req_pulse;
    logic               main_ack = 1'b0;
    logic               mon_ack = 1'b0;
    logic [NUM_REQ-1:0] pending;
    logic               busy;
    logic               timeout_err;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_active = 1'b0;
    bit   gap_armed = 1'b0;
    logic req_prev = 1'b0;
    int   low_cnt = 0;

    pcie_msi_if msi_bus ();

    assign req_pulse           = main_pulse | mon_pulse;
    assign msi_bus.app_msi_ack = main_ack | mon_ack;

    pcie_msi_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES),
        .MSI_TC     (3'd0)
    ) dut (
        .pld_clk    (clk),
        .rst        (rst),
        .msi_enable (msi_enable),
        .req_pulse  (req_pulse),
        .msi        (msi_bus.master),
        .pending    (pending),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        main_pulse = '0;
        main_ack   = 1'b0;
        msi_enable = 1'b0;
        gap_armed  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One-cycle pulse, sampled at the second posedge; returns just after that edge.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] v);
        @(posedge clk);
        #1 main_pulse = v;
        @(posedge clk);
        #1 main_pulse = '0;
    endtask

    task automatic waitIdle(input string name, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mon_active && !busy && !msi_bus.app_msi_req) done = 1'b1;
        end
        checkOutput({name, "_idle"}, {31'd0, done}, 32'd1);
        checkOutput({name, "_left"}, sb.size(), 32'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_req"}, {31'd0, msi_bus.app_msi_req}, 32'd0);
        checkOutput({name, "_num"}, {27'd0, msi_bus.app_msi_num}, 32'd0);
        checkOutput({name, "_tc"}, {29'd0, msi_bus.app_msi_tc}, 32'd0);
        checkOutput({name, "_pending"}, {24'd0, pending}, 32'd0);
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    endtask

    // Monitor and HIP model: compare every new request against the scoreboard, then ack or not.
    initial begin : monitor
        exp_t e;
        int   hi;
        bit   dropped;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_prev = 1'b0;
            end else if (msi_bus.app_msi_req && !req_prev) begin
                mon_active = 1'b1;
                if (gap_armed) checkOutput("gap_len_ok", {31'd0, low_cnt >= GAP_CYCLES + 1}, 32'd1);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_req: got num %0d, want no request", msi_bus.app_msi_num);
                    e = '{num: int'(msi_bus.app_msi_num), delay: 0, repulse: 1'b0};
                end else begin
                    e = sb.pop_front();
                    checkOutput("msi_num", {27'd0, msi_bus.app_msi_num}, 32'(e.num));
                end
                if (e.delay >= 0) begin
                    repeat (e.delay) begin
                        @(negedge clk);
                        checkOutput("req_held", {26'd0, msi_bus.app_msi_req, msi_bus.app_msi_num},
                                    {26'd0, 1'b1, 5'(e.num)});
                    end
                    mon_ack = 1'b1;
                    if (e.repulse) mon_pulse = NUM_REQ'(1) << e.num;
                    @(negedge clk);
                    mon_ack   = 1'b0;
                    mon_pulse = '0;
                    checkOutput("req_drop_ack", {31'd0, msi_bus.app_msi_req}, 32'd0);
                    checkOutput("pending_after_ack", {31'd0, pending[e.num]}, {31'd0, e.repulse});
                    low_cnt   = 1;
                    gap_armed = 1'b1;
                end else if (e.delay == -1) begin
                    hi      = 1;
                    dropped = 1'b0;
                    for (int c = 0; c < ACK_TIMEOUT + 4 && !dropped; c++) begin
                        @(negedge clk);
                        if (msi_bus.app_msi_req) hi++;
                        else dropped = 1'b1;
                    end
                    checkOutput("timeout_len", 32'(hi), 32'(ACK_TIMEOUT));
                    checkOutput("timeout_err_pulse", {31'd0, timeout_err}, 32'd1);
                    checkOutput("pending_kept", {31'd0, pending[e.num]}, 32'd1);
                    @(negedge clk);
                    checkOutput("timeout_err_one", {31'd0, timeout_err}, 32'd0);
                    low_cnt   = 2;
                    gap_armed = 1'b1;
                end
                req_prev   = msi_bus.app_msi_req;
                mon_active = 1'b0;
            end else begin
                req_prev = msi_bus.app_msi_req;
                if (!msi_bus.app_msi_req) low_cnt++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit seen;

        // T1: single event, reset values and pulse-to-req latency
        applyReset();
        @(negedge clk);
        checkResetOutputs("t1_reset");
        msi_enable = 1'b1;
        sb.push_back('{num: 2, delay: 2, repulse: 1'b0});
        applyStimulus(8'h04);
        @(negedge clk);
        checkOutput("t1_pending", {24'd0, pending}, 32'h04);
        checkOutput("t1_req_early", {31'd0, msi_bus.app_msi_req}, 32'd0);
        @(negedge clk);
        checkOutput("t1_req_rise", {31'd0, msi_bus.app_msi_req}, 32'd1);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        waitIdle("t1", 40);
        checkOutput("t1_pending_end", {24'd0, pending}, 32'h00);

        // T2: all requesters at once, grants in order 0..7
        applyReset();
        msi_enable = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) sb.push_back('{num: i, delay: 0, repulse: 1'b0});
        applyStimulus(8'hFF);
        waitIdle("t2", 200);
        checkOutput("t2_pending_end", {24'd0, pending}, 32'h00);

        // T3: repeated pulses coalesce; a pulse with the ack keeps the bit set
        applyReset();
        repeat (3) applyStimulus(8'h20);
        @(negedge clk);
        checkOutput("t3_coalesced", {24'd0, pending}, 32'h20);
        sb.push_back('{num: 5, delay: 1, repulse: 1'b1});
        sb.push_back('{num: 5, delay: 0, repulse: 1'b0});
        msi_enable = 1'b1;
        waitIdle("t3", 60);
        checkOutput("t3_pending_end", {24'd0, pending}, 32'h00);

        // T4: bit 1 never acked, bit 3 gets its turn, then bit 1 retries
        applyReset();
        msi_enable = 1'b1;
        sb.push_back('{num: 1, delay: -1, repulse: 1'b0});
        sb.push_back('{num: 3, delay: 0, repulse: 1'b0});
        sb.push_back('{num: 1, delay: 0, repulse: 1'b0});
        applyStimulus(8'h0A);
        waitIdle("t4", 200);
        checkOutput("t4_pending_end", {24'd0, pending}, 32'h00);

        // T5: enable gating holds events until msi_enable rises
        applyReset();
        applyStimulus(8'h41);
        repeat (10) @(negedge clk);
        checkOutput("t5_no_req", {31'd0, msi_bus.app_msi_req}, 32'd0);
        checkOutput("t5_pending", {24'd0, pending}, 32'h41);
        sb.push_back('{num: 0, delay: 0, repulse: 1'b0});
        sb.push_back('{num: 6, delay: 0, repulse: 1'b0});
        msi_enable = 1'b1;
        waitIdle("t5", 60);

        // T6: reset while requesting, then a stray ack
        applyReset();
        msi_enable = 1'b1;
        sb.push_back('{num: 4, delay: -2, repulse: 1'b0});
        applyStimulus(8'h10);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (msi_bus.app_msi_req) seen = 1'b1;
        end
        checkOutput("t6_req_seen", {31'd0, seen}, 32'd1);
        rst       = 1'b1;
        gap_armed = 1'b0;
        @(negedge clk);
        checkResetOutputs("t6_reset");
        rst      = 1'b0;
        main_ack = 1'b1;
        @(negedge clk);
        main_ack = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("t6_after_req", {31'd0, msi_bus.app_msi_req}, 32'd0);
        checkOutput("t6_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_after_pending", {24'd0, pending}, 32'h00);
        checkOutput("t6_left", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
